// File: rtl/blit_pkg.sv
// Shared definitions for the blit command sequencer: sequencer states,
// header field positions, argument limits and the privileged-opcode bit.
package blit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARGS  = 2'd1,
        ST_ISSUE = 2'd2
    } seq_state_e;

    localparam int WORD_W          = 32;
    localparam int OPCODE_MSB      = 31;
    localparam int OPCODE_LSB      = 24;
    localparam int NARGS_MSB       = 23;
    localparam int NARGS_LSB       = 21;
    localparam int IMM_MSB         = 20;
    localparam int IMM_LSB         = 0;
    localparam int PRIV_BIT        = 32;
    localparam int BLIT_MAX_ARGS   = 7;
    localparam int PRIV_OPCODE_BIT = 7;
    localparam int ARGS_W          = BLIT_MAX_ARGS * WORD_W;

endpackage

// File: rtl/blit_cmd_sequencer.sv
// Blit command sequencer: pulls a header word plus 0..7 argument words from
// the command FIFO, assembles them into one flat command and presents it to
// the blit engine with a valid/ready handshake.
// Optional feature macro: BLIT_PRIV_CHECK_EN -- when defined, privileged
// opcodes (opcode bit 7) arriving without the privilege bit are consumed and
// dropped, flagged by priv_err and counted in priv_err_count.
module blit_cmd_sequencer
    import blit_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cmd_queue_valid,
    input  logic [32:0]          cmd_queue_data,
    output logic                 cmd_queue_ready,
    output logic                 blit_cmd_valid,
    output logic [7:0]           blit_cmd_opcode,
    output logic [20:0]          blit_cmd_imm,
    output logic [ARGS_W-1:0]    blit_cmd_args,
    input  logic                 blit_cmd_ready,
    output logic                 seq_busy,
    output logic                 priv_err,
    output logic [ERR_CNT_W-1:0] priv_err_count
);

    seq_state_e          state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [2:0]          nargs_q, nargs_d;
    logic                drop_q, drop_d;
    logic [7:0]          opcode_q, opcode_d;
    logic [20:0]         imm_q, imm_d;
    logic [ARGS_W-1:0]   args_q, args_d;

    logic                accept_s;
    logic                hdr_drop_s;
    logic                priv_pulse_s;
    logic [2:0]          hdr_nargs_s;

    assign hdr_nargs_s = cmd_queue_data[NARGS_MSB:NARGS_LSB];

`ifdef BLIT_PRIV_CHECK_EN
    logic                 priv_err_q, priv_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // A privileged opcode without the privilege bit is dropped.
    assign hdr_drop_s = cmd_queue_data[OPCODE_LSB + PRIV_OPCODE_BIT]
                      & ~cmd_queue_data[PRIV_BIT];

    // Error pulse follows the dropping header; counter saturates at all-ones.
    always_comb begin
        priv_err_d = priv_pulse_s;
        err_cnt_d  = err_cnt_q;
        if (priv_pulse_s && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Privilege error flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            priv_err_q <= 1'b0;
            err_cnt_q  <= {ERR_CNT_W{1'b0}};
        end else begin
            priv_err_q <= priv_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign priv_err       = priv_err_q;
    assign priv_err_count = err_cnt_q;
`else
    logic unused_priv_s;

    // Privilege bit has no meaning when the check is compiled out.
    assign unused_priv_s  = cmd_queue_data[PRIV_BIT] ^ priv_pulse_s;
    assign hdr_drop_s     = 1'b0;
    assign priv_err       = 1'b0;
    assign priv_err_count = {ERR_CNT_W{1'b0}};
`endif

    // FIFO is read in every state except while a command waits for the engine.
    assign cmd_queue_ready = (state_q != ST_ISSUE);
    assign accept_s        = cmd_queue_valid & cmd_queue_ready;

    // Next-state, header decode and argument capture.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        nargs_d      = nargs_q;
        drop_d       = drop_q;
        opcode_d     = opcode_q;
        imm_d        = imm_q;
        args_d       = args_q;
        priv_pulse_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    opcode_d     = cmd_queue_data[OPCODE_MSB:OPCODE_LSB];
                    imm_d        = cmd_queue_data[IMM_MSB:IMM_LSB];
                    args_d       = {ARGS_W{1'b0}};
                    idx_d        = 3'd0;
                    nargs_d      = hdr_nargs_s;
                    drop_d       = hdr_drop_s;
                    priv_pulse_s = hdr_drop_s;
                    if (hdr_nargs_s != 3'd0) begin
                        state_d = ST_ARGS;
                    end else if (hdr_drop_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARGS: begin
                if (accept_s) begin
                    // Dropped commands drain their arguments without storing.
                    if (!drop_q) begin
                        args_d[{idx_q, 5'd0} +: WORD_W] = cmd_queue_data[WORD_W-1:0];
                    end else begin
                        args_d = args_q;
                    end
                    idx_d = idx_q + 3'd1;
                    if (idx_q == (nargs_q - 3'd1)) begin
                        state_d = drop_q ? ST_IDLE : ST_ISSUE;
                    end else begin
                        state_d = ST_ARGS;
                    end
                end else begin
                    state_d = ST_ARGS;
                end
            end
            ST_ISSUE: begin
                if (blit_cmd_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and command holding registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            nargs_q  <= 3'd0;
            drop_q   <= 1'b0;
            opcode_q <= 8'd0;
            imm_q    <= 21'd0;
            args_q   <= {ARGS_W{1'b0}};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            nargs_q  <= nargs_d;
            drop_q   <= drop_d;
            opcode_q <= opcode_d;
            imm_q    <= imm_d;
            args_q   <= args_d;
        end
    end

    assign blit_cmd_valid  = (state_q == ST_ISSUE);
    assign seq_busy        = (state_q != ST_IDLE);
    assign blit_cmd_opcode = opcode_q;
    assign blit_cmd_imm    = imm_q;
    assign blit_cmd_args   = args_q;

endmodule

// File: tb/tb_blit_cmd_sequencer.sv
// Directed testbench for blit_cmd_sequencer with a scoreboard of expected
// commands; expectations follow the BLIT_PRIV_CHECK_EN build setting.
module tb_blit_cmd_sequencer;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         cmd_queue_valid;
    logic [32:0]  cmd_queue_data;
    logic         cmd_queue_ready;
    logic         blit_cmd_valid;
    logic [7:0]   blit_cmd_opcode;
    logic [20:0]  blit_cmd_imm;
    logic [223:0] blit_cmd_args;
    logic         blit_cmd_ready;
    logic         seq_busy;
    logic         priv_err;
    logic [1:0]   priv_err_count;

    typedef struct {
        logic [7:0]   op;
        logic [20:0]  imm;
        logic [223:0] args;
    } exp_t;

    exp_t exp_q[$];
    int   err_n   = 0;
    int   chk_n   = 0;
    int   words_n = 0;
`ifdef BLIT_PRIV_CHECK_EN
    localparam bit PRIV_ON = 1'b1;
`else
    localparam bit PRIV_ON = 1'b0;
`endif

    blit_cmd_sequencer #(.ERR_CNT_W(2)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .cmd_queue_valid (cmd_queue_valid),
        .cmd_queue_data  (cmd_queue_data),
        .cmd_queue_ready (cmd_queue_ready),
        .blit_cmd_valid  (blit_cmd_valid),
        .blit_cmd_opcode (blit_cmd_opcode),
        .blit_cmd_imm    (blit_cmd_imm),
        .blit_cmd_args   (blit_cmd_args),
        .blit_cmd_ready  (blit_cmd_ready),
        .seq_busy        (seq_busy),
        .priv_err        (priv_err),
        .priv_err_count  (priv_err_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [223:0] obs, input logic [223:0] exp);
        chk_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one word and hold it until the sequencer takes it.
    task automatic send_word(input logic priv, input logic [31:0] w);
        int n = 0;
        cmd_queue_valid = 1'b1;
        cmd_queue_data  = {priv, w};
        @(negedge clock);
        while (!cmd_queue_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check("send_timeout", 224'd0, 224'd1);
        tick();
        cmd_queue_valid = 1'b0;
    endtask

    function automatic exp_t mk(input logic [7:0] op, input logic [20:0] imm,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3);
        exp_t e;
        e.op   = op;
        e.imm  = imm;
        e.args = '0;
        e.args[31:0]   = a0;
        e.args[63:32]  = a1;
        e.args[95:64]  = a2;
        e.args[127:96] = a3;
        return e;
    endfunction

    // Scoreboard: every engine handshake must match the oldest expectation.
    always @(negedge clock) begin
        if (reset_n && cmd_queue_valid && cmd_queue_ready) words_n++;
        if (reset_n && blit_cmd_valid && blit_cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cmd", {216'd0, blit_cmd_opcode}, 224'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("cmd_opcode", {216'd0, blit_cmd_opcode}, {216'd0, e.op});
                check("cmd_imm", {203'd0, blit_cmd_imm}, {203'd0, e.imm});
                check("cmd_args", blit_cmd_args, e.args);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w0;
        exp_t e;
        reset_n         = 1'b0;
        cmd_queue_valid = 1'b0;
        cmd_queue_data  = 33'd0;
        blit_cmd_ready  = 1'b1;
        #3;
        check("rst_valid", {223'd0, blit_cmd_valid}, 224'd0);
        check("rst_busy", {223'd0, seq_busy}, 224'd0);
        check("rst_args", blit_cmd_args, 224'd0);
        check("rst_cnt", {222'd0, priv_err_count}, 224'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", {223'd0, cmd_queue_ready}, 224'd1);

        // Zero-argument header issues in the next cycle.
        exp_q.push_back(mk(8'h01, 21'd0, 32'd0, 32'd0, 32'd0, 32'd0));
        send_word(1'b0, 32'h0100_0000);
        check("n0_valid_next", {223'd0, blit_cmd_valid}, 224'd1);
        tick();
        check("n0_idle", {223'd0, seq_busy}, 224'd0);

        // Three arguments with the engine stalling for four cycles.
        blit_cmd_ready = 1'b0;
        e = mk(8'h02, 21'd5, 32'hA, 32'hB, 32'hC, 32'd0);
        exp_q.push_back(e);
        send_word(1'b0, 32'h0260_0005);
        send_word(1'b1, 32'hA);
        send_word(1'b0, 32'hB);
        send_word(1'b0, 32'hC);
        check("n3_valid_next", {223'd0, blit_cmd_valid}, 224'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("hold_valid", {223'd0, blit_cmd_valid}, 224'd1);
            check("hold_qready", {223'd0, cmd_queue_ready}, 224'd0);
            check("hold_args", blit_cmd_args, e.args);
            check("hold_imm", {203'd0, blit_cmd_imm}, 224'd5);
            tick();
        end
        blit_cmd_ready = 1'b1;
        tick();
        check("n3_idle", {223'd0, seq_busy}, 224'd0);

        // Privileged opcode without privilege, then with privilege.
        if (!PRIV_ON) exp_q.push_back(mk(8'h80, 21'd0, 32'h11, 32'h22, 32'd0, 32'd0));
        w0 = words_n;
        send_word(1'b0, 32'h8040_0000);
        check("priv_pulse", {223'd0, priv_err}, {223'd0, PRIV_ON});
        check("priv_drop_valid", {223'd0, blit_cmd_valid}, 224'd0);
        send_word(1'b0, 32'h11);
        check("priv_pulse_end", {223'd0, priv_err}, 224'd0);
        send_word(1'b0, 32'h22);
        check("priv_words", words_n - w0, 224'd3);
        check("priv_cnt1", {222'd0, priv_err_count}, {223'd0, PRIV_ON});
        if (!PRIV_ON) tick();
        check("priv_drop_idle", {223'd0, seq_busy}, 224'd0);
        exp_q.push_back(mk(8'h80, 21'd0, 32'h33, 32'h44, 32'd0, 32'd0));
        send_word(1'b1, 32'h8040_0000);
        send_word(1'b0, 32'h33);
        send_word(1'b0, 32'h44);
        check("priv_ok_valid", {223'd0, blit_cmd_valid}, 224'd1);
        tick();

        // Counter saturation with five more violating headers.
        for (int i = 0; i < 5; i++) begin
            if (!PRIV_ON) exp_q.push_back(mk(8'h80, 21'd0, 32'd0, 32'd0, 32'd0, 32'd0));
            send_word(1'b0, 32'h8000_0000);
            if (!PRIV_ON) tick();
        end
        check("priv_cnt_sat", {222'd0, priv_err_count}, PRIV_ON ? 224'd3 : 224'd0);

        // Arguments arriving every other cycle.
        exp_q.push_back(mk(8'h03, 21'd7, 32'h1111, 32'h2222, 32'h3333, 32'h4444));
        send_word(1'b0, 32'h0380_0007);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("gap_busy", {223'd0, seq_busy}, 224'd1);
            check("gap_novalid", {223'd0, blit_cmd_valid}, 224'd0);
            send_word(1'b0, 32'h1111 * i);
        end
        check("gap_valid_next", {223'd0, blit_cmd_valid}, 224'd1);
        tick();

        // Reset in the middle of a four-argument command.
        send_word(1'b0, 32'h0480_0000);
        send_word(1'b0, 32'hDEAD);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", {223'd0, seq_busy}, 224'd0);
        check("midrst_args", blit_cmd_args, 224'd0);
        check("midrst_opcode", {216'd0, blit_cmd_opcode}, 224'd0);
        check("midrst_ready", {223'd0, cmd_queue_ready}, 224'd1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        tick();
        exp_q.push_back(mk(8'h05, 21'd9, 32'd0, 32'd0, 32'd0, 32'd0));
        send_word(1'b0, 32'h0500_0009);
        check("midrst_hdr_valid", {223'd0, blit_cmd_valid}, 224'd1);
        repeat (3) tick();
        check("sb_empty", exp_q.size(), 224'd0);

        $display("Result: errors=%0d of %0d checks", err_n, chk_n);
        $finish;
    end

endmodule
